// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/memory-stage RAM arbiter: sequencer states and
// the read-return tag that tells the cycle after issue who owns ram_rdata.
package mem_arb_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT1 = 1'b1
    } arb_state_e;

    typedef enum logic [2:0] {
        TAG_NONE   = 3'd0,
        TAG_FETCH  = 3'd1,
        TAG_MEM    = 3'd2,
        TAG_MEM_HI = 3'd3,
        TAG_MEM_LO = 3'd4
    } rtag_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch and the
// memory stage; memory stage wins, 32-bit PC push/pop is split into two beats.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [WORD_W-1:0] fetch_rdata,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_wide,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_stall,
    output logic              mem_done,
    output logic              mem_rvalid,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              pc_hi_wr,
    output logic              pc_lo_wr,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata
);

    arb_state_e        state_q, state_d;
    rtag_e             tag_q, tag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    always_comb begin
        state_d   = state_q;
        tag_d     = TAG_NONE;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        fetch_gnt = 1'b0;
        mem_stall = 1'b0;
        mem_done  = 1'b0;

        // Nothing reaches the RAM while reset is held, even with requests pending.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        ram_en   = 1'b1;
                        ram_we   = mem_we;
                        ram_addr = mem_addr;
                        if (mem_wide) begin
                            ram_wdata = mem_wdata[31:16];
                            addr_d    = mem_addr + ADDR_W'(1);
                            wdata_d   = mem_wdata[15:0];
                            we_d      = mem_we;
                            mem_stall = 1'b1;
                            state_d   = BEAT1;
                            tag_d     = mem_we ? TAG_NONE : TAG_MEM_HI;
                        end else begin
                            ram_wdata = mem_wdata[15:0];
                            mem_done  = 1'b1;
                            tag_d     = mem_we ? TAG_NONE : TAG_MEM;
                        end
                    end else if (fetch_req) begin
                        ram_en    = 1'b1;
                        ram_addr  = fetch_addr;
                        fetch_gnt = 1'b1;
                        tag_d     = TAG_FETCH;
                    end
                end
                BEAT1: begin
                    // Second half runs unconditionally; requesters are ignored here.
                    ram_en    = 1'b1;
                    ram_we    = we_q;
                    ram_addr  = addr_q;
                    ram_wdata = wdata_q;
                    mem_done  = 1'b1;
                    state_d   = IDLE;
                    tag_d     = we_q ? TAG_NONE : TAG_MEM_LO;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q   <= TAG_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign fetch_rvalid = (tag_q == TAG_FETCH);
    assign mem_rvalid   = (tag_q == TAG_MEM) || (tag_q == TAG_MEM_HI) || (tag_q == TAG_MEM_LO);
    assign pc_hi_wr     = (tag_q == TAG_MEM_HI);
    assign pc_lo_wr     = (tag_q == TAG_MEM_LO);

    assign fetch_rdata  = ram_rdata;
    assign mem_rdata    = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_rvalid;
    logic [15:0] fetch_rdata;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_wide = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_stall, mem_done, mem_rvalid, pc_hi_wr, pc_lo_wr;
    logic [15:0] mem_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] ram_mem [0:65535];

    int checks = 0;
    int errors = 0;

    // {fetch_gnt, fetch_rvalid, mem_stall, mem_done, mem_rvalid, pc_hi_wr, pc_lo_wr, ram_en, ram_we}
    logic [8:0] ctl;
    assign ctl = {fetch_gnt, fetch_rvalid, mem_stall, mem_done, mem_rvalid,
                  pc_hi_wr, pc_lo_wr, ram_en, ram_we};

    mem_port_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wide(mem_wide), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_done(mem_done),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pc_hi_wr(pc_hi_wr), .pc_lo_wr(pc_lo_wr),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model; contents are (re)loaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            ram_mem[16'h0010] <= 16'hA5A5;
            ram_mem[16'h0020] <= 16'h5555;
            ram_mem[16'h0100] <= 16'h0001;
            ram_mem[16'h0101] <= 16'h2345;
            ram_mem[16'h0200] <= 16'h1234;
            ram_mem[16'h0300] <= 16'hAAAA;
            ram_mem[16'h0301] <= 16'hBBBB;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic idle_inputs();
        fetch_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_wide = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        mem_req = 1'b1; fetch_req = 1'b1;
        #1;
        checks++;
        if (ctl !== 9'b0 || ram_addr !== 16'h0) begin
            errors++; $display("FAIL reset_held ctl=%b addr=%h want ctl=0 addr=0", ctl, ram_addr);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 9'b0) begin
            errors++; $display("FAIL reset_release ctl=%b want %b", ctl, 9'b0);
        end
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        #1;
        checks++;
        if (ctl !== 9'b1_0_0_0_0_0_0_1_0 || ram_addr !== 16'h0010) begin
            errors++; $display("FAIL fetch_issue ctl=%b addr=%h want 100000010 0010", ctl, ram_addr);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        checks++;
        if (ctl !== 9'b0_1_0_0_0_0_0_0_0 || fetch_rdata !== 16'hA5A5) begin
            errors++; $display("FAIL fetch_return ctl=%b data=%h want 010000000 a5a5", ctl, fetch_rdata);
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 16'h0020;
        mem_req = 1'b1; mem_we = 1'b0; mem_wide = 1'b0; mem_addr = 16'h0200;
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_1_0_0_0_1_0 || ram_addr !== 16'h0200) begin
            errors++; $display("FAIL contend_mem_wins ctl=%b addr=%h want 000100010 0200", ctl, ram_addr);
        end
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        checks++;
        if (ctl !== 9'b1_0_0_0_1_0_0_1_0 || ram_addr !== 16'h0020 || mem_rdata !== 16'h1234) begin
            errors++; $display("FAIL contend_fetch_next ctl=%b addr=%h data=%h want 100010010 0020 1234",
                               ctl, ram_addr, mem_rdata);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        checks++;
        if (ctl !== 9'b0_1_0_0_0_0_0_0_0 || fetch_rdata !== 16'h5555) begin
            errors++; $display("FAIL contend_fetch_data ctl=%b data=%h want 010000000 5555", ctl, fetch_rdata);
        end
    endtask

    task automatic test_wide_pop();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_wide = 1'b1; mem_addr = 16'h0100;
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        #1;
        checks++;
        if (ctl !== 9'b0_0_1_0_0_0_0_1_0 || ram_addr !== 16'h0100) begin
            errors++; $display("FAIL pop_beat0 ctl=%b addr=%h want 001000010 0100", ctl, ram_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_1_1_1_0_1_0 || ram_addr !== 16'h0101 || mem_rdata !== 16'h0001) begin
            errors++; $display("FAIL pop_beat1 ctl=%b addr=%h data=%h want 000111010 0101 0001",
                               ctl, ram_addr, mem_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_0_1_0_1_0_0 || mem_rdata !== 16'h2345) begin
            errors++; $display("FAIL pop_lo ctl=%b data=%h want 000010100 2345", ctl, mem_rdata);
        end
    endtask

    task automatic test_push_wrap();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_wide = 1'b1; mem_addr = 16'hFFFF;
        mem_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (ctl !== 9'b0_0_1_0_0_0_0_1_1 || ram_addr !== 16'hFFFF || ram_wdata !== 16'hDEAD) begin
            errors++; $display("FAIL push_beat0 ctl=%b addr=%h wd=%h want 001000011 ffff dead",
                               ctl, ram_addr, ram_wdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_1_0_0_0_1_1 || ram_addr !== 16'h0000 || ram_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL push_beat1_wrap ctl=%b addr=%h wd=%h want 000100011 0000 beef",
                               ctl, ram_addr, ram_wdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== 9'b0 || ram_mem[16'hFFFF] !== 16'hDEAD || ram_mem[16'h0000] !== 16'hBEEF) begin
            errors++; $display("FAIL push_result ctl=%b ram_ffff=%h ram_0000=%h want 0 dead beef",
                               ctl, ram_mem[16'hFFFF], ram_mem[16'h0000]);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_wide = 1'b0; mem_addr = 16'h0040;
        mem_wdata = 32'h1111CAFE;
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_1_0_0_0_1_1 || ram_wdata !== 16'hCAFE) begin
            errors++; $display("FAIL single_write ctl=%b wd=%h want 000100011 cafe", ctl, ram_wdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 9'b0 || ram_mem[16'h0040] !== 16'hCAFE) begin
            errors++; $display("FAIL single_write_after ctl=%b ram=%h want 0 cafe", ctl, ram_mem[16'h0040]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_wide = 1'b1; mem_addr = 16'h0100;
        #1;
        checks++;
        if (ctl !== 9'b0_0_1_0_0_0_0_1_0) begin
            errors++; $display("FAIL b2b_first ctl=%b want 001000010", ctl);
        end
        @(negedge clk);
        mem_addr = 16'h0300;
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_1_1_1_0_1_0 || ram_addr !== 16'h0101) begin
            errors++; $display("FAIL b2b_beat1 ctl=%b addr=%h want 000111010 0101", ctl, ram_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== 9'b0_0_1_0_1_0_1_1_0 || ram_addr !== 16'h0300 || mem_rdata !== 16'h2345) begin
            errors++; $display("FAIL b2b_second ctl=%b addr=%h data=%h want 001010110 0300 2345",
                               ctl, ram_addr, mem_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_1_1_1_0_1_0 || ram_addr !== 16'h0301 || mem_rdata !== 16'hAAAA) begin
            errors++; $display("FAIL b2b_second_beat1 ctl=%b addr=%h data=%h want 000111010 0301 aaaa",
                               ctl, ram_addr, mem_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_0_1_0_1_0_0 || mem_rdata !== 16'hBBBB) begin
            errors++; $display("FAIL b2b_second_lo ctl=%b data=%h want 000010100 bbbb", ctl, mem_rdata);
        end
    endtask

    task automatic test_reset_beat1();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_wide = 1'b1; mem_addr = 16'h0100;
        #1;
        checks++;
        if (ctl !== 9'b0_0_1_0_0_0_0_1_0) begin
            errors++; $display("FAIL rst_b1_beat0 ctl=%b want 001000010", ctl);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 9'b0) begin
            errors++; $display("FAIL rst_b1_abort ctl=%b want %b", ctl, 9'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 9'b0) begin
            errors++; $display("FAIL rst_b1_no_lo ctl=%b want %b", ctl, 9'b0);
        end
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_wide = 1'b0; mem_addr = 16'h0200;
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_1_0_0_0_1_0 || ram_addr !== 16'h0200) begin
            errors++; $display("FAIL rst_b1_next ctl=%b addr=%h want 000100010 0200", ctl, ram_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 9'b0_0_0_0_1_0_0_0_0 || mem_rdata !== 16'h1234) begin
            errors++; $display("FAIL rst_b1_next_data ctl=%b data=%h want 000010000 1234", ctl, mem_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_contention();
        test_wide_pop();
        test_push_wrap();
        test_single_write();
        test_back_to_back();
        test_reset_beat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
